// File: rtl/mem_bist_master_if.sv
// Native valid/ready memory bus between the BIST initiator and a responder.
// wstrb 4'b1111 marks a write, 4'b0000 a read; rdata is meaningful while ready is high.
interface mem_bist_master_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_bist_master.sv
// Memory BIST initiator: writes seed+i to base+4*i over a word range, reads it back,
// and reports pass/fail, a saturating error count and the first failing location.
module mem_bist_master #(
    parameter int unsigned COUNT_WIDTH    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ERR_WIDTH      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [31:0]            base_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    input  logic [31:0]            seed,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [ERR_WIDTH-1:0]   err_count,
    output logic [31:0]            first_err_addr,
    output logic [31:0]            first_err_data,
    mem_bist_master_if.master      mem
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE} state_t;

    localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam int unsigned TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t                 state, state_next;
    logic [31:0]            base_q, seed_q;
    logic [COUNT_WIDTH-1:0] count_q, idx;
    logic [TW-1:0]          wait_cnt;
    logic                   accept, stall, tmo_hit, rd_fire, last;
    logic [31:0]            cur_addr, cur_data;

    assign cur_addr = base_q + (32'(idx) << 2);
    assign cur_data = seed_q + 32'(idx);
    assign last     = (idx == count_q - COUNT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        stall         = 1'b0;
        tmo_hit       = 1'b0;
        rd_fire       = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        mem.mem_valid = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        mem.mem_wstrb = '0;
        unique case (state)
            // DONE already has busy low, so a start there is accepted just like in IDLE
            IDLE, DONE: begin
                done       = (state == DONE);
                state_next = IDLE;
                if (start) begin
                    accept     = 1'b1;
                    state_next = (word_count != '0) ? WR_REQ : DONE;
                end
            end
            WR_REQ, RD_REQ: begin
                busy          = 1'b1;
                mem.mem_valid = 1'b1;
                mem.mem_addr  = cur_addr;
                if (state == WR_REQ) begin
                    mem.mem_wdata = cur_data;
                    mem.mem_wstrb = '1;
                end
                if (mem.mem_ready) begin
                    rd_fire    = (state == RD_REQ);
                    state_next = (state == WR_REQ) ? WR_GAP : RD_GAP;
                end else if (TMO_EN && wait_cnt == TMO_LAST) begin
                    tmo_hit    = 1'b1;
                    state_next = DONE;
                end else begin
                    stall = 1'b1;
                end
            end
            WR_GAP: begin
                busy       = 1'b1;
                state_next = last ? RD_REQ : WR_REQ;
            end
            RD_GAP: begin
                busy       = 1'b1;
                state_next = last ? DONE : RD_REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q         <= '0;
            seed_q         <= '0;
            count_q        <= '0;
            idx            <= '0;
            wait_cnt       <= '0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else begin
            wait_cnt <= stall ? wait_cnt + TW'(1) : '0;
            if (accept) begin
                base_q         <= base_addr & ~32'd3;
                seed_q         <= seed;
                count_q        <= word_count;
                idx            <= '0;
                pass           <= (word_count == '0);
                timeout        <= 1'b0;
                err_count      <= '0;
                first_err_addr <= '0;
                first_err_data <= '0;
            end
            if (tmo_hit) begin
                timeout <= 1'b1;
                pass    <= 1'b0;
            end
            if (rd_fire && mem.mem_rdata != cur_data) begin
                if (err_count != '1) err_count <= err_count + ERR_WIDTH'(1);
                if (err_count == '0) begin
                    first_err_addr <= cur_addr;
                    first_err_data <= mem.mem_rdata;
                end
            end
            if (state == WR_GAP) idx <= last ? '0 : idx + COUNT_WIDTH'(1);
            if (state == RD_GAP) begin
                if (last) pass <= (err_count == '0);
                else      idx  <= idx + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_bist_master.sv
// Bench for mem_bist_master: memory responder with random wait states and fault injection,
// checked against a transaction-list model built from the write/read-back pattern rules.
module tb_mem_bist_master;
    localparam int unsigned CW  = 16;
    localparam int unsigned EW  = 16;
    localparam int unsigned TMO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   base_addr;
    logic [CW-1:0] word_count;
    logic [31:0]   seed;
    logic          busy, done, pass, timeout;
    logic [EW-1:0] err_count;
    logic [31:0]   first_err_addr, first_err_data;

    mem_bist_master_if bus();

    mem_bist_master #(.COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TMO), .ERR_WIDTH(EW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data), .mem(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  wstrb;
    } txn_t;

    txn_t        log_q[$];
    logic [31:0] tbmem [logic [31:0]];
    int unsigned proto_err;
    int unsigned wmax;
    bit          stall_all, fault_en;
    logic [31:0] fault_addr;
    int unsigned checks = 0;
    int unsigned errors = 0;

    // Responder and bus-rule monitor; decides ready for the next rising edge.
    bit          active = 1'b0, prev_valid = 1'b0, prev_fire = 1'b0, fire;
    int unsigned wcnt, wcur;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_wstrb;
    always @(negedge clk) begin
        if (prev_fire && bus.mem_valid) proto_err++;
        if (prev_valid && !prev_fire && bus.mem_valid &&
            (bus.mem_addr != prev_addr || bus.mem_wdata != prev_wdata || bus.mem_wstrb != prev_wstrb))
            proto_err++;
        if (bus.mem_valid && bus.mem_addr[1:0] != 2'b00) proto_err++;
        if (bus.mem_valid && !(bus.mem_wstrb == 4'hF || (bus.mem_wstrb == 4'h0 && bus.mem_wdata == 32'h0)))
            proto_err++;
        bus.mem_rdata = 32'h0;
        if (!bus.mem_valid) begin
            active        = 1'b0;
            bus.mem_ready = 1'b0;
        end else begin
            if (!active) begin
                active = 1'b1;
                wcnt   = 0;
                wcur   = $urandom_range(wmax, 0);
            end
            if (!stall_all && wcnt >= wcur) begin
                bus.mem_ready = 1'b1;
                if (bus.mem_wstrb == 4'h0) begin
                    if (fault_en && bus.mem_addr == fault_addr) bus.mem_rdata = 32'hDEADBEEF;
                    else if (tbmem.exists(bus.mem_addr))       bus.mem_rdata = tbmem[bus.mem_addr];
                end
            end else begin
                bus.mem_ready = 1'b0;
                wcnt++;
            end
        end
        fire = bus.mem_valid && bus.mem_ready;
        if (fire) begin
            if (bus.mem_wstrb == 4'hF) tbmem[bus.mem_addr] = bus.mem_wdata;
            log_q.push_back('{addr: bus.mem_addr, wdata: bus.mem_wdata, rdata: bus.mem_rdata, wstrb: bus.mem_wstrb});
        end
        prev_valid = bus.mem_valid;
        prev_fire  = fire;
        prev_addr  = bus.mem_addr;
        prev_wdata = bus.mem_wdata;
        prev_wstrb = bus.mem_wstrb;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a test and samples 1ns after each rising edge until one cycle past done.
    task automatic run(input logic [31:0] b, input int unsigned n, input logic [31:0] s, input bit inject,
                       output int unsigned done_cyc, output int unsigned busy_cyc,
                       output int unsigned valid_cyc, output int unsigned done_cnt);
        log_q.delete();
        proto_err = 0;
        done_cyc = 0; busy_cyc = 0; valid_cyc = 0; done_cnt = 0;
        base_addr  = b;
        word_count = CW'(n);
        seed       = s;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        base_addr  = $urandom;
        word_count = CW'($urandom);
        seed       = $urandom;
        for (int unsigned cyc = 1; cyc <= 600; cyc++) begin
            if (busy) busy_cyc++;
            if (bus.mem_valid) valid_cyc++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            start = inject && cyc == 5;
            if (done_cyc != 0 && cyc > done_cyc) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("done_seen", 64'(done_cyc != 0), 64'd1);
        check("done_width", 64'(done_cnt), 64'd1);
    endtask

    // Reference: N writes of seed+i to base+4i, then N reads; only faulted reads can mismatch.
    task automatic check_run(input logic [31:0] b, input int unsigned n, input logic [31:0] s,
                             input bit flt, input logic [31:0] faddr);
        logic [31:0] b0 = b & ~32'd3;
        logic [31:0] ea, ed, ret, fa = 32'h0, fd = 32'h0;
        int unsigned exp_err = 0;
        check("log_len", 64'(log_q.size()), 64'(2 * n));
        if (log_q.size() == 2 * n) begin
            for (int unsigned i = 0; i < n; i++) begin
                ea = b0 + 32'(4 * i);
                ed = s + 32'(i);
                check("wr_addr", 64'(log_q[i].addr), 64'(ea));
                check("wr_data", 64'(log_q[i].wdata), 64'(ed));
                check("wr_strb", 64'(log_q[i].wstrb), 64'hF);
                check("rd_addr", 64'(log_q[n + i].addr), 64'(ea));
                check("rd_strb", 64'(log_q[n + i].wstrb), 64'h0);
                ret = (flt && ea == faddr) ? 32'hDEADBEEF : ed;
                if (ret != ed) begin
                    if (exp_err == 0) begin fa = ea; fd = ret; end
                    exp_err++;
                end
            end
        end
        check("err_count", 64'(err_count), 64'(exp_err));
        check("first_err_addr", 64'(first_err_addr), 64'(fa));
        check("first_err_data", 64'(first_err_data), 64'(fd));
        check("pass", 64'(pass), 64'(exp_err == 0));
        check("timeout_clr", 64'(timeout), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        check("bus_rules", 64'(proto_err), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(bus.mem_valid), 64'd0);
        check({tag, "_addr"}, 64'(bus.mem_addr), 64'd0);
        check({tag, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
        check({tag, "_wstrb"}, 64'(bus.mem_wstrb), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_pass"}, 64'(pass), 64'd0);
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_err"}, 64'(err_count), 64'd0);
        check({tag, "_fea"}, 64'(first_err_addr), 64'd0);
        check({tag, "_fed"}, 64'(first_err_data), 64'd0);
    endtask

    initial begin
        int unsigned dc, bc, vc, dn, n;
        logic [31:0] b, s;

        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; seed = '0;
        wmax = 0; stall_all = 1'b0; fault_en = 1'b0; fault_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Empty range: immediate done, no bus traffic.
        run(32'h40, 0, 32'h1234, 1'b0, dc, bc, vc, dn);
        check("n0_done_cyc", 64'(dc), 64'd1);
        check("n0_valid_cyc", 64'(vc), 64'd0);
        check("n0_busy_cyc", 64'(bc), 64'd0);
        check("n0_pass", 64'(pass), 64'd1);
        check("n0_err", 64'(err_count), 64'd0);

        // Zero-wait responder: 8 transactions x 2 cycles.
        run(32'h10, 4, 32'h100, 1'b0, dc, bc, vc, dn);
        check_run(32'h10, 4, 32'h100, 1'b0, 32'h0);
        check("zw_busy_cyc", 64'(bc), 64'd16);
        check("zw_done_cyc", 64'(dc), 64'd17);

        // Multi-cycle responder plus an ignored start while busy.
        wmax = 4;
        run(32'h10, 4, 32'h100, 1'b1, dc, bc, vc, dn);
        check_run(32'h10, 4, 32'h100, 1'b0, 32'h0);

        // Faulty word at 0x18.
        fault_en = 1'b1; fault_addr = 32'h18;
        run(32'h10, 4, 32'h100, 1'b0, dc, bc, vc, dn);
        check_run(32'h10, 4, 32'h100, 1'b1, 32'h18);
        check("flt_err", 64'(err_count), 64'd1);
        check("flt_fea", 64'(first_err_addr), 64'h18);
        check("flt_fed", 64'(first_err_data), 64'hDEADBEEF);
        check("flt_pass", 64'(pass), 64'd0);
        fault_en = 1'b0;

        // Address and data wrap at 2^32.
        run(32'hFFFFFFF8, 3, 32'hFFFFFFFF, 1'b0, dc, bc, vc, dn);
        check_run(32'hFFFFFFF8, 3, 32'hFFFFFFFF, 1'b0, 32'h0);
        if (log_q.size() == 6) begin
            check("wrap_addr2", 64'(log_q[2].addr), 64'h0);
            check("wrap_data1", 64'(log_q[1].wdata), 64'h0);
            check("wrap_data2", 64'(log_q[2].wdata), 64'h1);
        end

        for (int unsigned k = 0; k < 6; k++) begin
            b = $urandom;
            s = $urandom;
            n = $urandom_range(12, 1);
            wmax = $urandom_range(5, 0);
            fault_en = 1'b1;
            fault_addr = ($urandom_range(1, 0) == 1) ? (b & ~32'd3) + 32'(4 * $urandom_range(n - 1, 0)) : 32'h3;
            run(b, n, s, 1'b0, dc, bc, vc, dn);
            check_run(b, n, s, 1'b1, fault_addr);
        end
        fault_en = 1'b0;

        // Responder never ready: timeout after TMO wait cycles.
        stall_all = 1'b1;
        run(32'h100, 4, 32'h5, 1'b0, dc, bc, vc, dn);
        check("tmo_flag", 64'(timeout), 64'd1);
        check("tmo_pass", 64'(pass), 64'd0);
        check("tmo_valid_cyc", 64'(vc), 64'(TMO));
        check("tmo_done_cyc", 64'(dc), 64'(TMO + 1));
        check("tmo_err", 64'(err_count), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("tmo_sticky", 64'(timeout), 64'd1);
        stall_all = 1'b0;

        // Reset in the middle of a read after one recorded mismatch.
        wmax = 3; fault_en = 1'b1; fault_addr = 32'h200;
        log_q.delete();
        base_addr = 32'h200; word_count = CW'(4); seed = 32'h77; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int unsigned cyc = 0; cyc < 200; cyc++) begin
            if (bus.mem_valid && bus.mem_wstrb == 4'h0 && err_count != '0) break;
            @(posedge clk); #1;
        end
        check("rst_mid_read_reached", 64'(bus.mem_valid && bus.mem_wstrb == 4'h0 && err_count != '0), 64'd1);
        check("rst_timeout_cleared", 64'(timeout), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("rst_mid");
        reset = 1'b0;
        fault_en = 1'b0;
        @(posedge clk); #1;

        tbmem.delete();
        run(32'h300, 5, 32'hA5A5A5A5, 1'b0, dc, bc, vc, dn);
        check_run(32'h300, 5, 32'hA5A5A5A5, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
